// File: rtl/pipelined_cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
// Latency: n/a (constants, types and elaboration-time checks only).
// Backpressure: n/a.
package pipelined_cla_pkg;

  localparam int GRP = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // WIDTH must split into STAGES equal segments, each a whole number of 4-bit groups.
  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (width >= 8) && (width % (GRP * stages) == 0);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead cell, used per bit group and again per block of groups.
// Latency: combinational.
// Backpressure: n/a.
module cla_group4
  import pipelined_cla_pkg::*;
(
  input  logic [GRP-1:0] p,
  input  logic [GRP-1:0] g,
  input  logic           ci,
  output logic           c1,
  output logic           c2,
  output logic           c3,
  output logic           gp,
  output logic           gg
);

  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign gp = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA add/subtract, one WIDTH/STAGES-bit segment resolved per stage.
// Latency: STAGES cycles, one op per cycle.
// Backpressure: whole pipe freezes while out_valid & ~out_ready; in_ready follows.
module pipelined_cla_addsub
  import pipelined_cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / GRP;
  localparam int NB  = (NG + GRP - 1) / GRP;

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_cla_addsub: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign b_eff    = (op_e'(sub) == OP_SUB) ? ~b : b;
  assign c_eff    = (op_e'(sub) == OP_SUB) ? 1'b1 : cin;

  // Stage k register: bits below (k+1)*SEG hold finished sum, bits above still hold A;
  // xb_q carries the not-yet-used upper part of effective B.
  logic [WIDTH-1:0] xa_q [STAGES];
  logic [WIDTH-1:0] xb_q [STAGES];
  logic             cy_q [STAGES];
  logic             vld_q[STAGES];
  logic             ovf_q, zero_q;

  logic [WIDTH-1:0] xa_d [STAGES];
  logic [WIDTH-1:0] xb_d [STAGES];
  logic             cy_d [STAGES];
  logic             cm_d [STAGES];
  logic             vld_d[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] xa_in, xb_in, xa_nx;
    logic             ci_in;
    logic [SEG-1:0]   sp, sg, sc;
    logic [NG-1:0]    gp, gg, gc;
    logic [NB-1:0]    blk_p, blk_g;
    logic [NB:0]      bc;

    if (k == 0) begin : g_src
      assign xa_in    = a;
      assign xb_in    = b_eff;
      assign ci_in    = c_eff;
      assign vld_d[k] = in_valid;
    end else begin : g_src
      assign xa_in    = xa_q[k-1];
      assign xb_in    = xb_q[k-1];
      assign ci_in    = cy_q[k-1];
      assign vld_d[k] = vld_q[k-1];
    end

    assign sp = xa_in[k*SEG +: SEG] ^ xb_in[k*SEG +: SEG];
    assign sg = xa_in[k*SEG +: SEG] & xb_in[k*SEG +: SEG];

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_group4 u_grp (
        .p  (sp[j*GRP +: GRP]),
        .g  (sg[j*GRP +: GRP]),
        .ci (gc[j]),
        .c1 (sc[j*GRP+1]),
        .c2 (sc[j*GRP+2]),
        .c3 (sc[j*GRP+3]),
        .gp (gp[j]),
        .gg (gg[j])
      );
      assign sc[j*GRP] = gc[j];
    end

    // Second lookahead level over blocks of four groups; missing groups are padded transparent.
    for (genvar bi = 0; bi < NB; bi++) begin : g_blk
      logic [GRP-1:0] bp, bg;
      logic [GRP-1:1] bcy;

      for (genvar t = 0; t < GRP; t++) begin : g_pad
        if (bi*GRP + t < NG) begin : g_real
          assign bp[t] = gp[bi*GRP+t];
          assign bg[t] = gg[bi*GRP+t];
        end else begin : g_fill
          assign bp[t] = 1'b1;
          assign bg[t] = 1'b0;
        end
      end

      cla_group4 u_blk (
        .p  (bp),
        .g  (bg),
        .ci (bc[bi]),
        .c1 (bcy[1]),
        .c2 (bcy[2]),
        .c3 (bcy[3]),
        .gp (blk_p[bi]),
        .gg (blk_g[bi])
      );

      assign gc[bi*GRP] = bc[bi];
      for (genvar t = 1; t < GRP; t++) begin : g_gc
        if (bi*GRP + t < NG) begin : g_use
          assign gc[bi*GRP+t] = bcy[t];
        end
      end
    end

    always_comb begin
      logic c;
      bc = '0;
      c  = ci_in;
      for (int m = 0; m < NB; m++) begin
        bc[m] = c;
        c     = blk_g[m] | (blk_p[m] & c);
      end
      bc[NB] = c;
    end

    always_comb begin
      xa_nx                = xa_in;
      xa_nx[k*SEG +: SEG]  = sp ^ sc;
    end

    assign xa_d[k] = xa_nx;
    assign xb_d[k] = xb_in;
    assign cy_d[k] = bc[NB];
    assign cm_d[k] = sc[SEG-1];
  end

  logic fovf, fzero;
  assign fovf  = cm_d[STAGES-1] ^ cy_d[STAGES-1];
  assign fzero = (xa_d[STAGES-1] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        xa_q[k]  <= '0;
        xb_q[k]  <= '0;
        cy_q[k]  <= 1'b0;
        vld_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        xa_q[k]  <= xa_d[k];
        xb_q[k]  <= xb_d[k];
        cy_q[k]  <= cy_d[k];
        vld_q[k] <= vld_d[k];
      end
      ovf_q  <= fovf;
      zero_q <= fzero;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = xa_q[STAGES-1];
  assign cout      = cy_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
